// File: rtl/os_operand_feeder.sv
// Operand stager for the output-stationary array: skews A/B lanes diagonally and sequences one tile (clear, stream, flush, done).
// Lane r/c is r+1/c+1 cycles from accept to bus; in_ready is high only in STREAM, and an in_valid=0 cycle injects a zero bubble.
module os_operand_feeder #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int K_MAX     = 255,
    parameter int PE_LAT    = 1,
    localparam int KW       = $clog2(K_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic [ROWS*WORD_SIZE-1:0] a_vec,
    input  logic [COLS*WORD_SIZE-1:0] b_vec,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
    output logic [COLS*WORD_SIZE-1:0] top_in_bus,
    output logic                      sys_rst,
    output logic                      busy,
    output logic                      done
);

    localparam int FLUSH_LEN = ROWS + COLS + PE_LAT - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] beat_cnt_q, beat_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          in_ready_q, sys_rst_q, busy_q, done_q;
    logic          accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (k_len_q != '0) ? STREAM : DONE;
            end
            STREAM: begin
                if (accept) begin
                    if (beat_cnt_q == k_len_q - KW'(1)) begin
                        beat_cnt_d = '0;
                        state_d    = FLUSH;
                    end else begin
                        beat_cnt_d = beat_cnt_q + KW'(1);
                    end
                end
            end
            FLUSH: begin
                // Drain until the last products have reached the far corner PE.
                if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            sys_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            in_ready_q  <= (state_d == STREAM);
            sys_rst_q   <= (state_d == CLEAR);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign in_ready = in_ready_q;
    assign sys_rst  = sys_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Triangular skew: A lane r is an (r+1)-deep shift register that runs every cycle.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        logic [WORD_SIZE-1:0] pipe_d [r+1];
        logic [WORD_SIZE-1:0] pipe_q [r+1];

        always_comb begin
            pipe_d[0] = accept ? a_vec[(r+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
            for (int j = 1; j < r + 1; j++) begin
                pipe_d[j] = pipe_q[j-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j < r + 1; j++) begin
                    pipe_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < r + 1; j++) begin
                    pipe_q[j] <= pipe_d[j];
                end
            end
        end

        assign left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE] = pipe_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        logic [WORD_SIZE-1:0] pipe_d [c+1];
        logic [WORD_SIZE-1:0] pipe_q [c+1];

        always_comb begin
            pipe_d[0] = accept ? b_vec[(c+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
            for (int j = 1; j < c + 1; j++) begin
                pipe_d[j] = pipe_q[j-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j < c + 1; j++) begin
                    pipe_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < c + 1; j++) begin
                    pipe_q[j] <= pipe_d[j];
                end
            end
        end

        assign top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE] = pipe_q[c];
    end

endmodule

// File: tb/tb_os_operand_feeder.sv
// Directed bench for os_operand_feeder on a 2x2 array with 16-bit words (flush length 4).
module tb_os_operand_feeder;
    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int W      = 16;
    localparam int K_MAX  = 255;
    localparam int PE_LAT = 1;
    localparam int KW     = 8;

    // Control bits packed as {sys_rst, in_ready, busy, done}.
    localparam logic [3:0] C_IDLE = 4'b0000;
    localparam logic [3:0] C_CLR  = 4'b1010;
    localparam logic [3:0] C_STR  = 4'b0110;
    localparam logic [3:0] C_BUSY = 4'b0010;
    localparam logic [3:0] C_DONE = 4'b0011;

    logic                clk;
    logic                rst;
    logic                start;
    logic [KW-1:0]       k_len;
    logic [ROWS*W-1:0]   a_vec;
    logic [COLS*W-1:0]   b_vec;
    logic                in_valid;
    logic                in_ready;
    logic [ROWS*W-1:0]   left_in_bus;
    logic [COLS*W-1:0]   top_in_bus;
    logic                sys_rst;
    logic                busy;
    logic                done;

    os_operand_feeder #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .K_MAX(K_MAX), .PE_LAT(PE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_vec(a_vec), .b_vec(b_vec), .in_valid(in_valid), .in_ready(in_ready),
        .left_in_bus(left_in_bus), .top_in_bus(top_in_bus),
        .sys_rst(sys_rst), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        st;
        logic [7:0]  k;
        logic        vld;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] el;
        logic [31:0] et;
        logic [3:0]  ectl;
    } vec_t;

    vec_t tv[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(input string tag, input logic st, input logic [7:0] k, input logic vld,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] el, input logic [31:0] et, input logic [3:0] ectl);
        vec_t v;
        v.tag = tag; v.st = st; v.k = k; v.vld = vld; v.a = a; v.b = b;
        v.el = el; v.et = et; v.ectl = ectl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic st, input logic [7:0] k, input logic vld,
                         input logic [31:0] a, input logic [31:0] b);
        start = st; k_len = k; in_valid = vld; a_vec = a; b_vec = b;
    endtask

    function automatic logic [3:0] ctl();
        return {sys_rst, in_ready, busy, done};
    endfunction

    initial begin
        logic done_seen;
        logic ctl_seen;

        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_left", left_in_bus, 32'h0);
        check("reset_top", top_in_bus, 32'h0);
        check("reset_ctl", {28'h0, ctl()}, {28'h0, C_IDLE});
        rst = 1'b1;

        // Skew with k_len=1; valid held high while not ready must be ignored.
        tv.push_back(mk("skew", 1, 1, 0, 0, 0, 0, 0, C_IDLE));
        tv.push_back(mk("skew", 0, 0, 0, 0, 0, 0, 0, C_CLR));
        tv.push_back(mk("skew", 0, 0, 1, 32'h0002_0001, 32'h0004_0003, 0, 0, C_STR));
        tv.push_back(mk("skew", 0, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001, 32'h0000_0003, C_BUSY));
        tv.push_back(mk("skew", 0, 0, 0, 0, 0, 32'h0002_0000, 32'h0004_0000, C_BUSY));
        tv.push_back(mk("skew", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("skew", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("skew", 0, 0, 0, 0, 0, 0, 0, C_DONE));
        tv.push_back(mk("skew", 0, 0, 0, 0, 0, 0, 0, C_IDLE));
        // k_len=0, plus a start in the DONE cycle.
        tv.push_back(mk("k0", 1, 0, 1, 32'h5555_5555, 32'h6666_6666, 0, 0, C_IDLE));
        tv.push_back(mk("k0", 0, 0, 1, 32'h5555_5555, 32'h6666_6666, 0, 0, C_CLR));
        tv.push_back(mk("k0", 1, 3, 1, 32'h5555_5555, 32'h6666_6666, 0, 0, C_DONE));
        tv.push_back(mk("k0", 0, 0, 0, 0, 0, 0, 0, C_IDLE));
        tv.push_back(mk("k0", 0, 0, 0, 0, 0, 0, 0, C_IDLE));
        // k_len=3 with a bubble on the 2nd STREAM cycle; starts during STREAM and DONE.
        tv.push_back(mk("stall", 1, 3, 0, 0, 0, 0, 0, C_IDLE));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 0, 0, C_CLR));
        tv.push_back(mk("stall", 0, 0, 1, 32'h0011_0010, 32'h0013_0012, 0, 0, C_STR));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_0012, C_STR));
        tv.push_back(mk("stall", 1, 1, 1, 32'h0021_0020, 32'h0023_0022, 32'h0011_0000, 32'h0013_0000, C_STR));
        tv.push_back(mk("stall", 0, 0, 1, 32'h0031_0030, 32'h0033_0032, 32'h0000_0020, 32'h0000_0022, C_STR));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 32'h0021_0030, 32'h0023_0032, C_BUSY));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 32'h0031_0000, 32'h0033_0000, C_BUSY));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("stall", 1, 2, 0, 0, 0, 0, 0, C_DONE));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 0, 0, C_IDLE));
        tv.push_back(mk("stall", 0, 0, 0, 0, 0, 0, 0, C_IDLE));
        // Signed extremes, then a second tile started the cycle after done.
        tv.push_back(mk("signed", 1, 1, 0, 0, 0, 0, 0, C_IDLE));
        tv.push_back(mk("signed", 0, 0, 0, 0, 0, 0, 0, C_CLR));
        tv.push_back(mk("signed", 0, 0, 1, 32'h8000_7FFF, 32'hFFFF_8000, 0, 0, C_STR));
        tv.push_back(mk("signed", 0, 0, 0, 0, 0, 32'h0000_7FFF, 32'h0000_8000, C_BUSY));
        tv.push_back(mk("signed", 0, 0, 0, 0, 0, 32'h8000_0000, 32'hFFFF_0000, C_BUSY));
        tv.push_back(mk("signed", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("signed", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("signed", 0, 0, 0, 0, 0, 0, 0, C_DONE));
        tv.push_back(mk("b2b", 1, 2, 0, 0, 0, 0, 0, C_IDLE));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 0, 0, C_CLR));
        tv.push_back(mk("b2b", 0, 0, 1, 32'h0102_0101, 32'h0104_0103, 0, 0, C_STR));
        tv.push_back(mk("b2b", 0, 0, 1, 32'h0202_0201, 32'h0204_0203, 32'h0000_0101, 32'h0000_0103, C_STR));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 32'h0102_0201, 32'h0104_0203, C_BUSY));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 32'h0202_0000, 32'h0204_0000, C_BUSY));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 0, 0, C_BUSY));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 0, 0, C_DONE));
        tv.push_back(mk("b2b", 0, 0, 0, 0, 0, 0, 0, C_IDLE));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d] left", tv[i].tag, i), left_in_bus, tv[i].el);
            check($sformatf("%s[%0d] top", tv[i].tag, i), top_in_bus, tv[i].et);
            check($sformatf("%s[%0d] ctl", tv[i].tag, i), {28'h0, ctl()}, {28'h0, tv[i].ectl});
            drive(tv[i].st, tv[i].k, tv[i].vld, tv[i].a, tv[i].b);
        end

        // Asynchronous reset in the middle of a k_len=8 tile with data in flight.
        @(negedge clk); drive(1, 8, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_seq stream_ctl", {28'h0, ctl()}, {28'h0, C_STR});
        drive(0, 0, 1, 32'h1111_2222, 32'h3333_4444);
        @(negedge clk);
        check("rst_seq left1", left_in_bus, 32'h0000_2222);
        drive(0, 0, 1, 32'h5555_6666, 32'h7777_8888);
        @(negedge clk);
        check("rst_seq left2", left_in_bus, 32'h1111_6666);
        check("rst_seq top2", top_in_bus, 32'h3333_8888);
        #2 rst = 1'b0;
        #1;
        check("rst_async left", left_in_bus, 32'h0);
        check("rst_async top", top_in_bus, 32'h0);
        check("rst_async ctl", {28'h0, ctl()}, {28'h0, C_IDLE});
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        ctl_seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (busy || in_ready || sys_rst) ctl_seen = 1'b1;
        end
        check("post_rst no_done", {31'h0, done_seen}, 32'h0);
        check("post_rst idle", {31'h0, ctl_seen}, 32'h0);

        // A fresh k_len=0 tile confirms the FSM came back in IDLE.
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        check("post_rst clr", {28'h0, ctl()}, {28'h0, C_CLR});
        @(negedge clk);
        check("post_rst done", {28'h0, ctl()}, {28'h0, C_DONE});
        @(negedge clk);
        check("post_rst idle2", {28'h0, ctl()}, {28'h0, C_IDLE});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
